// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one UART byte transmitter among NUM_REQ byte streams
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 2,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 1024,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [0:0] S_IDLE = 1'b0, S_LOCKED = 1'b1;
  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, rr_q, rr_d, pick;
  logic [BW-1:0]      burst_q, burst_d, burst_n;
  logic [SW-1:0]      stall_q, stall_d, stall_n;
  logic [NUM_REQ-1:0] own_hot;
  logic               locked, own_valid, xfer, rel;
  int                 j;
  assign locked    = state_q == S_LOCKED;
  assign own_valid = req_valid[owner_q];
  assign own_hot   = NUM_REQ'(1) << owner_q;
  assign tx_data   = req_data[8*owner_q +: 8];
  assign tx_valid  = locked & own_valid;
  assign req_ready = (locked & tx_ready) ? own_hot : '0;
  assign grant     = locked ? own_hot : '0;
  assign busy      = locked;
  assign xfer      = tx_valid & tx_ready;
  assign burst_n   = burst_q + 1'b1;
  assign stall_n   = stall_q + 1'b1;
  // EOL, burst limit and stall timeout collapse into one release path
  assign rel = locked & ((xfer & ((tx_data == EOL_CHAR) | (burst_n == BW'(MAX_BURST))))
                       | (!own_valid & (stall_n == SW'(IDLE_TIMEOUT))));
  // descending scan so the requester closest to rr_q is the final assignment
  always_comb begin
    pick = rr_q;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_q) + i) % NUM_REQ;
      if (req_valid[j]) pick = IW'(j);
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    stall_d = stall_q;
    if (!locked) begin
      if (|req_valid) begin
        state_d = S_LOCKED;
        owner_d = pick;
      end
    end else if (rel) begin
      state_d = S_IDLE;
      rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      burst_d = '0;
      stall_d = '0;
    end else begin
      burst_d = xfer ? burst_n : burst_q;
      stall_d = own_valid ? '0 : stall_n;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end
endmodule
